id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage core. Sits directly upstream of the ALU.
- Selects operands: EX/MEM and MEM/WB forwarding, plus the immediate.
- Detects load-use hazards and inserts bubbles.
- Drives A, B and ALU_opcode to the ALU, and carries writeback control alongside.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard the held entry and the incoming entry (branch redirect)
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- rs1_addr, rs2_addr  in  RADDR_W  source register numbers
- rs1_data, rs2_data  in  XLEN  register file read data
- imm  in  XLEN  sign-extended immediate
- use_imm  in  1  B = imm instead of rs2; rs2 is then unused
- alu_op  in  4  ALU opcode: 0000 add, 0110 sub, 0010 nand
- rd_addr  in  RADDR_W  destination register
- reg_write, mem_read  in  1  writeback enable; load instruction
- exmem_reg_write, exmem_mem_read  in  1  EX/MEM control
- exmem_rd  in  RADDR_W  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writeback enable
- memwb_rd  in  RADDR_W  MEM/WB destination
- memwb_result  in  XLEN  MEM/WB writeback data
- ex_valid  out  1  held entry valid
- ex_ready  in  1  downstream consumes the held entry this cycle
- A, B  out  XLEN  ALU operands (registered)
- ALU_opcode  out  4  registered alu_op
- ex_rd  out  RADDR_W  registered destination
- ex_reg_write, ex_mem_read  out  1  registered control
- ex_store_data  out  XLEN  forwarded rs2 value, independent of use_imm

Behaviour:
- Reset: all outputs registered and zero (ex_valid=0, A=B=0, ALU_opcode=0000, ex_rd=0, control=0). in_ready evaluates to 1 after reset.
- Forwarding (combinational, evaluated at capture):
  - Per operand, priority is EX/MEM match, then MEM/WB match, then register file.
  - EX/MEM match: exmem_reg_write && !exmem_mem_read && exmem_rd==rsX && rsX!=0.
  - MEM/WB match: memwb_reg_write && memwb_rd==rsX && rsX!=0.
  - rsX==0 always yields 0, regardless of rs data.
- Hazard: hz = in_valid && (
  - (ex_valid && ex_mem_read && ex_rd!=0 && uses(ex_rd)), or
  - (exmem_mem_read && exmem_reg_write && exmem_rd!=0 && uses(exmem_rd))).
  - uses(r) = rs1_addr==r || (!use_imm && rs2_addr==r).
  - Result: two bubbles worst case behind a load.
- in_ready = (!ex_valid || ex_ready) && !hz && !flush.
- Capture when in_valid && in_ready:
  - A = fwd(rs1), B = use_imm ? imm : fwd(rs2), ex_store_data = fwd(rs2).
  - All other fields copied; ex_valid <= 1.
  - Latency 1 cycle.
- No capture and ex_ready: ex_valid <= 0. A hazard bubble is therefore ex_valid=0.
- Downstream stall (ex_valid && !ex_ready): every registered output holds stable. Forwarded values are not re-sampled.
- flush has priority over capture and hold: ex_valid <= 0, data fields unchanged.
- Simultaneous flush and rst: rst wins. Reset mid-stall drops the held entry.
- Data registers may update only on capture. ex_reg_write and ex_mem_read are qualified with ex_valid before leaving the stage, i.e. forced 0 when ex_valid=0.

Decomposition:
- Shared package core_pkg:
  - ALU opcode constants ALU_ADD=4'b0000, ALU_SUB=4'b0110, ALU_NAND=4'b0010.
  - XLEN and RADDR_W.
- One sub-module: fwd_mux, a single-operand forwarding priority mux including the x0 rule, instantiated twice.
- Hazard logic stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> ex_valid=0, A=B=0, ALU_opcode=0000; first capture the cycle after rst drops.
- Basic capture: rs1_data=5, rs2_data=3, alu_op=0110, ex_ready=1 -> next cycle A=5, B=3, ALU_opcode=0110, ex_valid=1.
- Forwarding priority: rs1=7 with exmem_rd=7 (result 0x11) and memwb_rd=7 (result 0x22) -> A=0x11. With exmem_reg_write=0 -> A=0x22. With rs1=0 and all matches set -> A=0.
- Load-use: a load to r4 in stage, next instruction reads r4 -> in_ready=0 for 2 cycles, ex_valid bubbles; third cycle captures with A=memwb_result (0xABCD). use_imm=1 with rs2=r4 only -> no stall.
- Downstream stall: ex_ready=0 for 3 cycles -> outputs constant, in_ready=0, no instruction lost or duplicated.
- Flush: flush=1 with in_valid=1 and ex_valid=1 -> next cycle ex_valid=0, ex_reg_write=0, incoming instruction discarded.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and ALU opcode constants
package core_pkg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NAND = 4'b0010;
endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - single-operand forwarding priority mux with x0 rule
import core_pkg::*;

module fwd_mux #(
  parameter int XLEN    = core_pkg::XLEN,
  parameter int RADDR_W = core_pkg::RADDR_W
) (
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]    rs_data,
  input  logic               exmem_reg_write,
  input  logic               exmem_mem_read,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    fwd_data
);
  logic rs_zero;
  logic exmem_hit;
  logic memwb_hit;

  // A load in EX/MEM has no data yet; the hazard logic stalls for that case.
  assign rs_zero   = (rs_addr == '0);
  assign exmem_hit = exmem_reg_write && !exmem_mem_read && (exmem_rd == rs_addr) && !rs_zero;
  assign memwb_hit = memwb_reg_write && (memwb_rd == rs_addr) && !rs_zero;

  always_comb begin
    fwd_data = rs_data;
    if (rs_zero)        fwd_data = '0;
    else if (exmem_hit) fwd_data = exmem_result;
    else if (memwb_hit) fwd_data = memwb_result;
  end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute register with forwarding and load-use stall
import core_pkg::*;

module id_ex_stage #(
  parameter int XLEN    = core_pkg::XLEN,
  parameter int RADDR_W = core_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm,
  input  logic               use_imm,
  input  logic [3:0]         alu_op,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_write,
  input  logic               mem_read,
  input  logic               exmem_reg_write,
  input  logic               exmem_mem_read,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    A,
  output logic [XLEN-1:0]    B,
  output logic [3:0]         ALU_opcode,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic [XLEN-1:0]    ex_store_data
);
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            reg_write_q;
  logic            mem_read_q;
  logic            hz;
  logic            capture;

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .rs_addr         (rs1_addr),
    .rs_data         (rs1_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_mem_read  (exmem_mem_read),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .rs_addr         (rs2_addr),
    .rs_data         (rs2_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_mem_read  (exmem_mem_read),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs2)
  );

  function automatic logic uses(input logic [RADDR_W-1:0] r);
    return (rs1_addr == r) || (!use_imm && (rs2_addr == r));
  endfunction

  // A load in ID/EX or EX/MEM cannot forward yet: up to two bubbles behind it.
  assign hz = in_valid && (
      (ex_valid && mem_read_q && (ex_rd != '0) && uses(ex_rd)) ||
      (exmem_mem_read && exmem_reg_write && (exmem_rd != '0) && uses(exmem_rd)));

  assign in_ready = (!ex_valid || ex_ready) && !hz && !flush;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      A             <= '0;
      B             <= '0;
      ALU_opcode    <= ALU_ADD;
      ex_rd         <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      ex_store_data <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (capture) begin
      ex_valid      <= 1'b1;
      A             <= fwd_rs1;
      B             <= use_imm ? imm : fwd_rs2;
      ALU_opcode    <= alu_op;
      ex_rd         <= rd_addr;
      reg_write_q   <= reg_write;
      mem_read_q    <= mem_read;
      ex_store_data <= fwd_rs2;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_reg_write = reg_write_q && ex_valid;
  assign ex_mem_read  = mem_read_q && ex_valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
import core_pkg::*;

module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, ex_rd;
  logic [31:0] rs1_data, rs2_data, imm, exmem_result, memwb_result;
  logic        use_imm, reg_write, mem_read;
  logic [3:0]  alu_op, ALU_opcode;
  logic        exmem_reg_write, exmem_mem_read, memwb_reg_write;
  logic        ex_valid, ex_ready, ex_reg_write, ex_mem_read;
  logic [31:0] A, B, ex_store_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .use_imm(use_imm), .alu_op(alu_op), .rd_addr(rd_addr),
    .reg_write(reg_write), .mem_read(mem_read),
    .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .A(A), .B(B), .ALU_opcode(ALU_opcode),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_mem_read = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
  endtask

  task automatic set_instr(input logic [4:0] r1, input logic [31:0] d1,
                           input logic [4:0] r2, input logic [31:0] d2,
                           input logic [4:0] rd, input logic [3:0] op,
                           input logic ui, input logic [31:0] im,
                           input logic rw, input logic mr);
    rs1_addr = r1; rs1_data = d1; rs2_addr = r2; rs2_data = d2;
    rd_addr = rd; alu_op = op; use_imm = ui; imm = im;
    reg_write = rw; mem_read = mr;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; ex_ready = 1'b1;
    clear_fwd();
    set_instr(5'd1, 32'h5, 5'd2, 32'h3, 5'd3, ALU_SUB, 1'b0, 32'h0, 1'b1, 1'b0);

    // reset held for two cycles with a valid instruction presented
    step(); step();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_A", A, 32'h0);
    check("rst_B", B, 32'h0);
    check("rst_opcode", 32'(ALU_opcode), 32'(ALU_ADD));
    check("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);

    rst = 1'b0;
    settle();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    check("cap_ex_valid", 32'(ex_valid), 32'd1);
    check("cap_A", A, 32'h5);
    check("cap_B", B, 32'h3);
    check("cap_opcode", 32'(ALU_opcode), 32'(ALU_SUB));
    check("cap_ex_rd", 32'(ex_rd), 32'd3);
    check("cap_ex_reg_write", 32'(ex_reg_write), 32'd1);
    check("cap_store", ex_store_data, 32'h3);

    // forwarding priority on rs1
    set_instr(5'd7, 32'h99, 5'd2, 32'h3, 5'd8, ALU_ADD, 1'b0, 32'h0, 1'b1, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_result = 32'h22;
    step();
    check("fwd_exmem_A", A, 32'h11);
    exmem_reg_write = 1'b0;
    step();
    check("fwd_memwb_A", A, 32'h22);
    set_instr(5'd0, 32'h55, 5'd0, 32'h66, 5'd8, ALU_NAND, 1'b0, 32'h0, 1'b1, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    step();
    check("fwd_x0_A", A, 32'h0);
    check("fwd_x0_B", B, 32'h0);
    check("fwd_nand_op", 32'(ALU_opcode), 32'(ALU_NAND));

    // immediate replaces B, store data still carries forwarded rs2
    set_instr(5'd0, 32'h55, 5'd7, 32'h66, 5'd9, ALU_ADD, 1'b1, 32'h100, 1'b0, 1'b0);
    exmem_rd = 5'd7; memwb_rd = 5'd7;
    step();
    check("imm_B", B, 32'h100);
    check("imm_store", ex_store_data, 32'h11);
    check("imm_A", A, 32'h0);

    // load-use: load r4, then consumer of r4
    clear_fwd();
    set_instr(5'd1, 32'h10, 5'd0, 32'h0, 5'd4, ALU_ADD, 1'b1, 32'h8, 1'b1, 1'b1);
    step();
    check("ld_ex_mem_read", 32'(ex_mem_read), 32'd1);
    set_instr(5'd4, 32'hDEAD, 5'd5, 32'h7, 5'd6, ALU_ADD, 1'b0, 32'h0, 1'b1, 1'b0);
    settle();
    check("lu_stall1_ready", 32'(in_ready), 32'd0);
    step();
    exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_rd = 5'd4;
    settle();
    check("lu_bubble1_valid", 32'(ex_valid), 32'd0);
    check("lu_stall2_ready", 32'(in_ready), 32'd0);
    step();
    clear_fwd();
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hABCD;
    settle();
    check("lu_bubble2_valid", 32'(ex_valid), 32'd0);
    check("lu_ready", 32'(in_ready), 32'd1);
    step();
    check("lu_cap_valid", 32'(ex_valid), 32'd1);
    check("lu_cap_A", A, 32'hABCD);
    check("lu_cap_rd", 32'(ex_rd), 32'd6);

    // immediate form: rs2 matching the load's rd does not stall
    clear_fwd();
    set_instr(5'd1, 32'h10, 5'd0, 32'h0, 5'd4, ALU_ADD, 1'b1, 32'h8, 1'b1, 1'b1);
    step();
    set_instr(5'd1, 32'h10, 5'd4, 32'h0, 5'd5, ALU_ADD, 1'b1, 32'h20, 1'b1, 1'b0);
    settle();
    check("imm_nostall_ready", 32'(in_ready), 32'd1);
    step();
    check("imm_nostall_valid", 32'(ex_valid), 32'd1);
    check("imm_nostall_mr", 32'(ex_mem_read), 32'd0);

    // downstream stall: held entry must not change or be resampled
    ex_ready = 1'b0;
    set_instr(5'd2, 32'h77, 5'd3, 32'h1, 5'd10, ALU_SUB, 1'b0, 32'h0, 1'b1, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h33;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_ready", 32'(in_ready), 32'd0);
      step();
      check("stall_valid", 32'(ex_valid), 32'd1);
      check("stall_A", A, 32'h10);
      check("stall_B", B, 32'h20);
      check("stall_rd", 32'(ex_rd), 32'd5);
    end
    clear_fwd();
    ex_ready = 1'b1;
    settle();
    check("unstall_ready", 32'(in_ready), 32'd1);
    step();
    check("unstall_A", A, 32'h77);
    check("unstall_rd", 32'(ex_rd), 32'd10);
    in_valid = 1'b0;
    step();
    check("nodup_valid", 32'(ex_valid), 32'd0);

    // flush drops both the held and the incoming entry
    in_valid = 1'b1;
    set_instr(5'd1, 32'h44, 5'd2, 32'h0, 5'd11, ALU_ADD, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("pre_flush_valid", 32'(ex_valid), 32'd1);
    flush = 1'b1;
    set_instr(5'd1, 32'h55, 5'd2, 32'h0, 5'd12, ALU_ADD, 1'b0, 32'h0, 1'b1, 1'b0);
    settle();
    check("flush_ready", 32'(in_ready), 32'd0);
    step();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_reg_write", 32'(ex_reg_write), 32'd0);
    check("flush_A_kept", A, 32'h44);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_discard", 32'(ex_valid), 32'd0);

    // reset during a downstream stall, with flush also asserted
    in_valid = 1'b1;
    step();
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    ex_ready = 1'b0; rst = 1'b1; flush = 1'b1;
    step();
    check("rst_stall_valid", 32'(ex_valid), 32'd0);
    check("rst_stall_A", A, 32'h0);
    check("rst_stall_rd", 32'(ex_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
